// File: rtl/multicycle_ctrl_unit.sv
// Multi-cycle RV32I control sequencer: registered opcode decode plus a
// FETCH/DECODE/EXEC/MEM/WB FSM with req/ack handshakes and timeout traps.
module multicycle_ctrl_unit #(
  parameter bit          EN_MULDIV = 1'b1,
  parameter int unsigned WAIT_MAX  = 16,
  parameter int unsigned CNT_W     = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [6:0] funct7,
  input  logic       imem_ack,
  input  logic       dmem_ack,
  input  logic       mdu_done,
  output logic       imem_req,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       mdu_start,
  output logic       ir_we,
  output logic       pc_we,
  output logic       reg_we,
  output logic [2:0] imm_type,
  output logic [2:0] alu_op,
  output logic       alu_src,
  output logic       rd_src,
  output logic       pc_to_reg_src,
  output logic       mem_to_reg,
  output logic [1:0] branch,
  output logic       trap,
  output logic [1:0] trap_cause,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StTrap   = 3'd6
  } state_e;

  typedef struct packed {
    logic [2:0] imm_type;
    logic [2:0] alu_op;
    logic       alu_src;
    logic       rd_src;
    logic       pc_to_reg_src;
    logic       mem_to_reg;
    logic [1:0] branch;
    logic       dmem_we;
    logic       is_mul;
    logic       is_load;
    logic       is_store;
    logic       is_branch;
  } dec_t;

  localparam bit             TimeoutEn = (WAIT_MAX != 0);
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(WAIT_MAX - 1);

  state_e           state_q, state_d;
  dec_t             dec_q, dec_d, dec_new, dec_dflt;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             exec_first_q;
  logic             illegal;
  logic             timeout;

  assign timeout = TimeoutEn && (cnt_q == CntLast);

  // Opcode decode; only captured while in DECODE.
  always_comb begin
    dec_dflt        = '0;
    dec_dflt.alu_op = 3'd2;
    dec_new         = dec_dflt;
    illegal         = 1'b0;
    case (opcode)
      7'b0110011: begin
        dec_new.alu_src = 1'b1;
        if (funct7 == 7'b0000001) begin
          if (EN_MULDIV) begin
            dec_new.alu_op = 3'd6;
            dec_new.is_mul = 1'b1;
          end else begin
            illegal = 1'b1;
          end
        end else if (funct7 == 7'b0000000 || funct7 == 7'b0100000) begin
          dec_new.alu_op = 3'd0;
        end else begin
          illegal = 1'b1;
        end
      end
      7'b0000011: begin
        dec_new.mem_to_reg = 1'b1;
        dec_new.is_load    = 1'b1;
      end
      7'b0010011: dec_new.alu_op = 3'd1;
      7'b1100111: begin
        dec_new.alu_op = 3'd3;
        dec_new.rd_src = 1'b1;
        dec_new.branch = 2'b10;
      end
      7'b0100011: begin
        dec_new.imm_type = 3'd1;
        dec_new.dmem_we  = 1'b1;
        dec_new.is_store = 1'b1;
      end
      7'b1100011: begin
        dec_new.imm_type  = 3'd2;
        dec_new.alu_op    = 3'd4;
        dec_new.alu_src   = 1'b1;
        dec_new.branch    = 2'b01;
        dec_new.is_branch = 1'b1;
      end
      7'b0010111: begin
        dec_new.imm_type      = 3'd3;
        dec_new.rd_src        = 1'b1;
        dec_new.pc_to_reg_src = 1'b1;
      end
      7'b0110111: begin
        dec_new.imm_type = 3'd3;
        dec_new.alu_op   = 3'd5;
      end
      7'b1101111: begin
        dec_new.imm_type = 3'd4;
        dec_new.rd_src   = 1'b1;
        dec_new.branch   = 2'b11;
      end
      default: illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      dec_q        <= '0;
      cause_q      <= 2'b00;
      cnt_q        <= '0;
      exec_first_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      dec_q        <= dec_d;
      cause_q      <= cause_d;
      cnt_q        <= cnt_d;
      exec_first_q <= (state_d == StExec) && (state_q != StExec);
    end
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      StIdle:  state_d = StFetch;
      StFetch: begin
        if (imem_ack) begin
          state_d = StDecode;
        end else if (timeout) begin
          state_d = StTrap;
          cause_d = 2'b10;
        end
      end
      StDecode: begin
        if (illegal) begin
          state_d = StTrap;
          cause_d = 2'b01;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        if (dec_q.is_mul) begin
          if (mdu_done) begin
            state_d = StWb;
          end else if (timeout) begin
            state_d = StTrap;
            cause_d = 2'b11;
          end
        end else if (dec_q.is_load || dec_q.is_store) begin
          state_d = StMem;
        end else if (dec_q.is_branch) begin
          state_d = StFetch;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        if (dmem_ack) begin
          state_d = dec_q.is_store ? StFetch : StWb;
        end else if (timeout) begin
          state_d = StTrap;
          cause_d = 2'b10;
        end
      end
      StWb:    state_d = StFetch;
      StTrap:  state_d = StFetch;
      default: state_d = StIdle;
    endcase

    // Only waiting states loop on themselves, so any state change restarts the count.
    cnt_d = (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);

    dec_d = dec_q;
    if (state_d == StTrap) begin
      dec_d = dec_dflt;
    end else if (state_q == StDecode) begin
      dec_d = dec_new;
    end
  end

  always_comb begin
    imem_req      = (state_q == StFetch);
    ir_we         = (state_q == StFetch) && imem_ack;
    dmem_req      = (state_q == StMem);
    mdu_start     = (state_q == StExec) && dec_q.is_mul && exec_first_q;
    reg_we        = (state_q == StWb);
    trap          = (state_q == StTrap);
    pc_we         = ((state_q == StExec) && dec_q.is_branch) ||
                    ((state_q == StMem) && dec_q.is_store && dmem_ack) ||
                    (state_q == StWb) || (state_q == StTrap);
    dmem_we       = dec_q.dmem_we;
    imm_type      = dec_q.imm_type;
    alu_op        = dec_q.alu_op;
    alu_src       = dec_q.alu_src;
    rd_src        = dec_q.rd_src;
    pc_to_reg_src = dec_q.pc_to_reg_src;
    mem_to_reg    = dec_q.mem_to_reg;
    branch        = dec_q.branch;
    trap_cause    = cause_q;
    state_o       = state_q;
  end

endmodule

// File: tb/tb_multicycle_ctrl_unit.sv
// Scoreboard bench: each instruction pushes its expected retirement record; a monitor
// pops and compares whenever the DUT retires (pc_we) an instruction or trap.
module tb_multicycle_ctrl_unit;

  typedef struct {
    int st, trap, cause, lat, dreq, ms, rw, alu, imm, br, asrc, rds, p2r, m2r, we;
  } exp_t;

  logic       clk;
  logic       rst       [2];
  logic [6:0] opcode    [2];
  logic [6:0] funct7    [2];
  logic       imem_ack  [2];
  logic       dmem_ack  [2];
  logic       mdu_done  [2];
  logic       imem_req  [2];
  logic       dmem_req  [2];
  logic       dmem_we   [2];
  logic       mdu_start [2];
  logic       ir_we     [2];
  logic       pc_we     [2];
  logic       reg_we    [2];
  logic [2:0] imm_type  [2];
  logic [2:0] alu_op    [2];
  logic       alu_src   [2];
  logic       rd_src    [2];
  logic       p2r       [2];
  logic       mem_to_reg[2];
  logic [1:0] branch    [2];
  logic       trap      [2];
  logic [1:0] trap_cause[2];
  logic [2:0] state_o   [2];

  int   tests = 0;
  int   fails = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t mon_e;
  int   lat[2], dreq[2], ms[2], rw[2];

  multicycle_ctrl_unit #(.EN_MULDIV(1'b1), .WAIT_MAX(16), .CNT_W(5)) u_dut0 (
    .clk(clk), .rst(rst[0]), .opcode(opcode[0]), .funct7(funct7[0]),
    .imem_ack(imem_ack[0]), .dmem_ack(dmem_ack[0]), .mdu_done(mdu_done[0]),
    .imem_req(imem_req[0]), .dmem_req(dmem_req[0]), .dmem_we(dmem_we[0]),
    .mdu_start(mdu_start[0]), .ir_we(ir_we[0]), .pc_we(pc_we[0]), .reg_we(reg_we[0]),
    .imm_type(imm_type[0]), .alu_op(alu_op[0]), .alu_src(alu_src[0]), .rd_src(rd_src[0]),
    .pc_to_reg_src(p2r[0]), .mem_to_reg(mem_to_reg[0]), .branch(branch[0]),
    .trap(trap[0]), .trap_cause(trap_cause[0]), .state_o(state_o[0])
  );

  multicycle_ctrl_unit #(.EN_MULDIV(1'b0), .WAIT_MAX(4), .CNT_W(5)) u_dut1 (
    .clk(clk), .rst(rst[1]), .opcode(opcode[1]), .funct7(funct7[1]),
    .imem_ack(imem_ack[1]), .dmem_ack(dmem_ack[1]), .mdu_done(mdu_done[1]),
    .imem_req(imem_req[1]), .dmem_req(dmem_req[1]), .dmem_we(dmem_we[1]),
    .mdu_start(mdu_start[1]), .ir_we(ir_we[1]), .pc_we(pc_we[1]), .reg_we(reg_we[1]),
    .imm_type(imm_type[1]), .alu_op(alu_op[1]), .alu_src(alu_src[1]), .rd_src(rd_src[1]),
    .pc_to_reg_src(p2r[1]), .mem_to_reg(mem_to_reg[1]), .branch(branch[1]),
    .trap(trap[1]), .trap_cause(trap_cause[1]), .state_o(state_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int k, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s dut%0d: got %0d expected %0d", nm, k, act, exp);
    end
  endtask

  task automatic push(input int k, input int st, input int tr, input int cause, input int lt,
                      input int dq, input int m, input int r, input int alu, input int imm,
                      input int br, input int asrc, input int rds, input int pr,
                      input int m2r, input int we);
    exp_t e;
    e = '{st, tr, cause, lt, dq, m, r, alu, imm, br, asrc, rds, pr, m2r, we};
    if (k == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  // Drive one instruction; ack counts are 0-based cycle indices within each state.
  task automatic run(input int k, input logic [6:0] op, input logic [6:0] f7,
                     input int iw, input int dw, input int mw);
    int fc = 0, dc = 0, mc = 0;
    bit done = 0;
    opcode[k] = op;
    funct7[k] = f7;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      imem_ack[k] = (state_o[k] == 3'd1) && (fc == iw);
      dmem_ack[k] = (state_o[k] == 3'd4) && (dc == dw);
      mdu_done[k] = (state_o[k] == 3'd3) && (mc == mw);
      if (state_o[k] == 3'd1) fc++;
      if (state_o[k] == 3'd4) dc++;
      if (state_o[k] == 3'd3) mc++;
      #1;
      done = pc_we[k];
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL retire_timeout dut%0d: got no pc_we expected retire op=%b", k, op);
    end
  endtask

  always @(negedge clk) begin
    #2;
    for (int k = 0; k < 2; k++) begin
      if (rst[k]) begin
        lat[k] = 0; dreq[k] = 0; ms[k] = 0; rw[k] = 0;
      end else if (state_o[k] != 3'd0) begin
        lat[k]++;
        if (dmem_req[k]) dreq[k]++;
        if (mdu_start[k]) ms[k]++;
        if (reg_we[k]) rw[k]++;
        if (pc_we[k]) begin
          if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
            tests++;
            fails++;
            $display("FAIL unexpected_retire dut%0d: got state %0d expected none", k,
                     state_o[k]);
          end else begin
            mon_e = (k == 0) ? q0.pop_front() : q1.pop_front();
            chk("state", k, int'(state_o[k]), mon_e.st);
            chk("trap", k, int'(trap[k]), mon_e.trap);
            chk("trap_cause", k, int'(trap_cause[k]), mon_e.cause);
            chk("latency", k, lat[k], mon_e.lat);
            chk("dmem_req_cycles", k, dreq[k], mon_e.dreq);
            chk("mdu_start_pulses", k, ms[k], mon_e.ms);
            chk("reg_we_cycles", k, rw[k], mon_e.rw);
            chk("alu_op", k, int'(alu_op[k]), mon_e.alu);
            chk("imm_type", k, int'(imm_type[k]), mon_e.imm);
            chk("branch", k, int'(branch[k]), mon_e.br);
            chk("alu_src", k, int'(alu_src[k]), mon_e.asrc);
            chk("rd_src", k, int'(rd_src[k]), mon_e.rds);
            chk("pc_to_reg_src", k, int'(p2r[k]), mon_e.p2r);
            chk("mem_to_reg", k, int'(mem_to_reg[k]), mon_e.m2r);
            chk("dmem_we", k, int'(dmem_we[k]), mon_e.we);
          end
          lat[k] = 0; dreq[k] = 0; ms[k] = 0; rw[k] = 0;
        end
      end
    end
  end

  initial begin
    bit in_mem;
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; opcode[k] = '0; funct7[k] = '0;
      imem_ack[k] = 1'b0; dmem_ack[k] = 1'b0; mdu_done[k] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_state", k, int'(state_o[k]), 0);
      chk("rst_trap_cause", k, int'(trap_cause[k]), 0);
      chk("rst_alu_op", k, int'(alu_op[k]), 0);
      chk("rst_imem_req", k, int'(imem_req[k]), 0);
      chk("rst_pc_we", k, int'(pc_we[k]), 0);
    end

    // DUT0: EN_MULDIV=1, WAIT_MAX=16
    rst[0] = 1'b0;
    push(0, 5, 0, 0, 4, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0); run(0, 7'b0110011, 7'h00, 0, 0, -1);
    push(0, 5, 0, 0, 8, 4, 0, 1, 2, 0, 0, 0, 0, 0, 1, 0); run(0, 7'b0000011, 7'h00, 0, 3, -1);
    push(0, 4, 0, 0, 4, 1, 0, 0, 2, 1, 0, 0, 0, 0, 0, 1); run(0, 7'b0100011, 7'h00, 0, 0, -1);
    push(0, 3, 0, 0, 3, 0, 0, 0, 4, 2, 1, 1, 0, 0, 0, 0); run(0, 7'b1100011, 7'h00, 0, 0, -1);
    push(0, 5, 0, 0, 8, 0, 1, 1, 6, 0, 0, 1, 0, 0, 0, 0); run(0, 7'b0110011, 7'h01, 0, 0, 4);
    push(0, 5, 0, 0, 4, 0, 0, 1, 2, 4, 3, 0, 1, 0, 0, 0); run(0, 7'b1101111, 7'h00, 0, 0, -1);
    push(0, 5, 0, 0, 4, 0, 0, 1, 2, 3, 0, 0, 1, 1, 0, 0); run(0, 7'b0010111, 7'h00, 0, 0, -1);
    push(0, 6, 1, 1, 3, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0); run(0, 7'b1111111, 7'h00, 0, 0, -1);
    push(0, 6, 1, 1, 3, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0); run(0, 7'b0110011, 7'h02, 0, 0, -1);
    push(0, 5, 0, 1, 6, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0); run(0, 7'b0010011, 7'h00, 2, 0, -1);
    push(0, 6, 1, 3, 19, 0, 1, 0, 2, 0, 0, 0, 0, 0, 0, 0); run(0, 7'b0110011, 7'h01, 0, 0, 99);
    push(0, 5, 0, 3, 4, 0, 0, 1, 3, 0, 2, 0, 1, 0, 0, 0); run(0, 7'b1100111, 7'h00, 0, 0, -1);
    push(0, 5, 0, 3, 4, 0, 0, 1, 5, 3, 0, 0, 0, 0, 0, 0); run(0, 7'b0110111, 7'h00, 0, 0, -1);
    push(0, 5, 0, 3, 4, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0); run(0, 7'b0110011, 7'h20, 0, 0, -1);

    // Reset asserted in the middle of a load's MEM wait
    opcode[0] = 7'b0000011;
    funct7[0] = 7'h00;
    in_mem = 1'b0;
    for (int c = 0; c < 20 && !in_mem; c++) begin
      @(negedge clk);
      imem_ack[0] = (state_o[0] == 3'd1);
      dmem_ack[0] = 1'b0;
      in_mem = (state_o[0] == 3'd4);
    end
    imem_ack[0] = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_state", 0, int'(state_o[0]), 4);
    chk("pre_rst_dmem_req", 0, int'(dmem_req[0]), 1);
    #3 rst[0] = 1'b1;
    #1;
    chk("async_rst_dmem_req", 0, int'(dmem_req[0]), 0);
    chk("async_rst_state", 0, int'(state_o[0]), 0);
    chk("async_rst_mem_to_reg", 0, int'(mem_to_reg[0]), 0);

    // DUT1: EN_MULDIV=0, WAIT_MAX=4
    @(negedge clk);
    rst[1] = 1'b0;
    push(1, 6, 1, 1, 3, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0); run(1, 7'b0110011, 7'h01, 0, 0, 0);
    push(1, 6, 1, 2, 5, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0); run(1, 7'b0110011, 7'h00, 99, 0, -1);
    push(1, 5, 0, 2, 7, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0); run(1, 7'b0110011, 7'h00, 3, 0, -1);
    push(1, 6, 1, 2, 8, 4, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0); run(1, 7'b0100011, 7'h00, 0, 99, -1);
    push(1, 5, 0, 2, 8, 4, 0, 1, 2, 0, 0, 0, 0, 0, 1, 0); run(1, 7'b0000011, 7'h00, 0, 3, -1);

    @(negedge clk);
    rst[1] = 1'b1;
    repeat (3) @(negedge clk);
    chk("queue0_drained", 0, q0.size(), 0);
    chk("queue1_drained", 1, q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl_unit.md
Name: multicycle_ctrl_unit

Overview:
Multi-cycle RV32I control sequencer; successor to the single-cycle opcode decoder. Combines the same opcode decode, registered once per instruction, with an FSM that sequences FETCH/DECODE/EXEC/MEM/WB. Uses req/ack handshakes to instruction memory, data memory and an optional multi-cycle mul/div unit. Sits between the datapath and memories, driving all datapath enables and mux selects, and raises traps for illegal opcodes and handshake timeouts.

Parameters:
EN_MULDIV, 1, 1 = accept R-type with funct7=7'b0000001 (M extension) via mdu handshake; 0 = treat as illegal
WAIT_MAX, 16, max cycles any handshake may wait before timeout trap; 0 disables timeout
CNT_W, 5, width of wait counter; must hold WAIT_MAX

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
opcode  input  7  IR[6:0], valid from DECODE onward
funct7  input  7  IR[31:25]
imem_ack  input  1  instruction word valid this cycle
dmem_ack  input  1  data access complete this cycle
mdu_done  input  1  mul/div result valid this cycle
imem_req  output  1  instruction fetch request
dmem_req  output  1  data memory request
dmem_we  output  1  1 = store, 0 = load (valid with dmem_req)
mdu_start  output  1  one-cycle start pulse to mul/div unit
ir_we  output  1  latch instruction register
pc_we  output  1  update PC (datapath selects target via branch/trap)
reg_we  output  1  register file write enable
imm_type  output  3  I=0 S=1 B=2 U=3 J=4
alu_op  output  3  R=0 I=1 Add=2 Jalr=3 B=4 Lui=5 MulDiv=6
alu_src  output  1  0 imm, 1 reg
rd_src  output  1  0 ALU/mem result, 1 PC-based
pc_to_reg_src  output  1  0 PC+4, 1 PC+imm
mem_to_reg  output  1  0 ALU, 1 load data
branch  output  2  00 none, 01 B, 10 jalr, 11 jal
trap  output  1  one-cycle trap pulse
trap_cause  output  2  01 illegal, 10 memory timeout, 11 mdu timeout; held until next trap
state_o  output  3  current state (debug)

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6.
- Reset: state IDLE. All outputs 0, including decoded fields and trap_cause. IDLE -> FETCH unconditionally on the next edge. Reset mid-handshake drops all requests asynchronously.
- Outputs are Moore on state plus the registered decode fields. Exception: ir_we and pc_we are qualified by the ack in their state.
- FETCH: imem_req=1 until imem_ack. On the ack cycle, ir_we=1 and next state is DECODE.
- DECODE: decode opcode/funct7 with the RV32I table (R, Load, I-ALU, JALR 7'b1100111, Store, Branch, AUIPC, LUI, JAL). Register imm_type/alu_op/alu_src/rd_src/pc_to_reg_src/mem_to_reg/branch/dmem_we.
  - Unknown opcode, R-type with funct7 not in {0000000, 0100000, 0000001}, or M-type with EN_MULDIV=0 -> TRAP, cause 01.
  - Otherwise -> EXEC.
- EXEC:
  - M-type: mdu_start=1 on the first EXEC cycle only; stay until mdu_done, then -> WB.
  - Load/Store -> MEM.
  - Branch: pc_we=1, -> FETCH.
  - All others -> WB.
- MEM: dmem_req=1 until dmem_ack.
  - Store: on ack, pc_we=1, -> FETCH.
  - Load: on ack, -> WB.
- WB: reg_we=1, pc_we=1, -> FETCH. Stores and branches never reach WB.
- Wait counter:
  - Clears on entry to FETCH, MEM, or M-type EXEC; increments each cycle without ack/done.
  - If WAIT_MAX != 0 and count == WAIT_MAX-1 with no ack -> TRAP: cause 10 from FETCH/MEM, 11 from EXEC.
  - Ack on that same cycle wins; no trap.
  - Late acks after leaving the state are ignored.
- TRAP: one cycle. trap=1, pc_we=1 (datapath loads trap vector), all requests 0, decoded fields cleared to default (I imm, Add, branch 00). -> FETCH.
- Latency: ALU instructions with zero-wait memory take 4 cycles FETCH-to-FETCH; branch 3; store 4; load 5.

Test Plan:
- Reset then ADD (opcode 0110011, funct7 0) with imem_ack on the first FETCH cycle -> state sequence 0,1,2,3,5,1; reg_we=1 only in WB; alu_op=0, alu_src=1.
- LW with dmem_ack delayed 3 cycles -> dmem_req high 4 cycles, dmem_we=0, mem_to_reg=1, reg_we pulse in WB; total 8 cycles FETCH-to-FETCH.
- SW then BEQ -> SW: dmem_we=1, pc_we at MEM ack, no WB. BEQ: imm_type=2, branch=01, pc_we in EXEC, reg_we never 1.
- MUL (funct7 0000001) with EN_MULDIV=1 and mdu_done after 5 cycles -> mdu_start exactly one pulse, alu_op=6, WB follows. With EN_MULDIV=0 -> trap=1, trap_cause=01.
- WAIT_MAX=4, imem_ack never asserted -> trap pulses on the 4th FETCH cycle, cause 10, then FETCH. Repeat with ack on exactly the 4th cycle -> no trap, DECODE.
- Opcode 7'b1111111 -> TRAP, cause 01, pc_we=1. Assert rst during a MEM wait -> dmem_req drops immediately, state 0.
